fifo_rd_stream: RTL and testbench

//  Read-side consumer for the dual-clock FIFO, living in the read clock domain.
//  - Pops words through the FIFO read port (rempty/rinc/rdata).
//  - Re-presents them as a registered valid/ready stream.
//  - Holds a 2-entry prefetch/skid buffer, so no combinational path runs from
//    out_ready to rinc.
//  - An enable/drain state machine starts and stops consumption cleanly.

---
 rtl/fifo_rd_pkg.sv | 13 +
 rtl/fifo_rd_stream_rd_skid_buf.sv | 58 +++++
 rtl/fifo_rd_stream.sv | 74 +++++++
 tb/tb_fifo_rd_stream.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream consumer.
package fifo_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   localparam int OCC_W = 2;
   localparam int CNT_W = 16;

endpackage

// File: rtl/fifo_rd_stream_rd_skid_buf.sv
// Two-entry output/skid register pair; out_data is the head word and skid_data
// holds the second word while the sink stalls.
module rd_skid_buf
   import fifo_rd_pkg::*;
#(
   parameter int DSIZE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [DSIZE-1:0] push_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [DSIZE-1:0] out_data,
   output logic [OCC_W-1:0] occ
);

   logic [DSIZE-1:0] skid_data;
   logic             xfer;

   assign out_valid = (occ != '0);
   assign xfer      = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ       <= '0;
         out_data  <= '0;
         skid_data <= '0;
      end else begin
         case ({push, xfer})
            2'b10: begin
               if (occ == '0) begin
                  out_data <= push_data;
                  occ      <= OCC_W'(1);
               end else begin
                  skid_data <= push_data;
                  occ       <= OCC_W'(2);
               end
            end
            2'b11: begin
               // Head leaves while a new word arrives; occupancy is unchanged.
               if (occ == OCC_W'(2)) begin
                  out_data  <= skid_data;
                  skid_data <= push_data;
               end else begin
                  out_data <= push_data;
               end
            end
            2'b01: begin
               if (occ == OCC_W'(2)) out_data <= skid_data;
               occ <= occ - OCC_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer: pops the dual-clock FIFO and presents a registered
// valid/ready stream. Optional word counter under FIFO_RD_WORD_CNT_EN.
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int DSIZE = 8
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   input  logic             en,
   output logic             out_valid,
   output logic [DSIZE-1:0] out_data,
   input  logic             out_ready,
   output logic             busy,
   output rd_state_t        state
`ifdef FIFO_RD_WORD_CNT_EN
   ,
   output logic [CNT_W-1:0] word_cnt
`endif
);

   // Stream handshake: a word moves when out_valid & out_ready at a rising rclk
   // edge; out_valid never depends on out_ready and out_data is held while stalled.

   logic [OCC_W-1:0] occ;
   logic             xfer;

   // rinc depends only on registered state, so out_ready never reaches it.
   assign rinc = (state == RUN) & ~rempty & (occ < OCC_W'(2));
   assign xfer = out_valid & out_ready;
   assign busy = (state != IDLE) | (occ != '0);

   rd_skid_buf #(.DSIZE(DSIZE)) u_buf (
      .clk       (rclk),
      .rst_n     (rrst_n),
      .push      (rinc),
      .push_data (rdata),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .occ       (occ)
   );

   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (en) state <= RUN;
            RUN:     if (!en) state <= DRAIN;
            DRAIN: begin
               if (en)
                  state <= RUN;
               else if ((occ == '0) || ((occ == OCC_W'(1)) && xfer))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FIFO_RD_WORD_CNT_EN
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n)
         word_cnt <= '0;
      else if (xfer && (word_cnt != {CNT_W{1'b1}}))
         word_cnt <= word_cnt + CNT_W'(1);
   end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: queue-based FIFO model feeds the read port,
// scoreboard queue tracks popped words and checks them at each stream transfer.
module tb_fifo_rd_stream;
   import fifo_rd_pkg::*;

   localparam int W = 8;

   logic          rclk = 1'b0;
   logic          rrst_n;
   logic          rempty;
   logic [W-1:0]  rdata;
   logic          rinc;
   logic          en;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_ready;
   logic          busy;
   rd_state_t     state;
`ifdef FIFO_RD_WORD_CNT_EN
   logic [15:0]   word_cnt;
`endif

   fifo_rd_stream #(.DSIZE(W)) dut (
      .rclk      (rclk),
      .rrst_n    (rrst_n),
      .rempty    (rempty),
      .rdata     (rdata),
      .rinc      (rinc),
      .en        (en),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .state     (state)
`ifdef FIFO_RD_WORD_CNT_EN
      ,
      .word_cnt  (word_cnt)
`endif
   );

   always #5 rclk = ~rclk;

   logic [W-1:0] fifo_q[$];
   logic [W-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int pop_cnt = 0;
   int xfer_cnt = 0;
   int first_pop_cyc = -1;
   int first_xfer_cyc = -1;
   int last_xfer_cyc = -1;
   int exp_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge rclk);
      #1;
   endtask

   // FIFO model drive, then monitor/scoreboard for the upcoming edge.
   always @(negedge rclk) begin
      cyc++;
      if (!rrst_n) begin
         fifo_q.delete();
         exp_q.delete();
         exp_cnt = 0;
         rempty = 1'b1;
         rdata  = '0;
      end else begin
         rempty = (fifo_q.size() == 0);
         rdata  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
         #1;
         chk("out_valid_vs_inflight", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
         if (exp_q.size() != 0) chk("busy_with_data", {31'd0, busy}, 32'd1);
         if (out_valid && out_ready && exp_q.size() != 0) begin
            chk("stream_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            xfer_cnt++;
            if (exp_cnt < 65535) exp_cnt++;
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
         end
         if (rinc) begin
            chk("rinc_not_empty", {31'd0, rempty}, 32'd0);
            chk("rinc_below_two", {31'd0, exp_q.size() < 2}, 32'd1);
            if (fifo_q.size() != 0) exp_q.push_back(fifo_q.pop_front());
            pop_cnt++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
         end
      end
   end

   int p0, x0;

   initial begin
      rrst_n = 1'b0; en = 1'b0; out_ready = 1'b0; rempty = 1'b1; rdata = '0;
      wait_cyc(3);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_rinc", {31'd0, rinc}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_out_data", {24'd0, out_data}, 32'd0);
      chk("rst_state", {30'd0, state}, {30'd0, IDLE});
      rrst_n = 1'b1;
      wait_cyc(2);

      // Streaming 0x01..0x10 at full rate
      for (int i = 1; i <= 16; i++) fifo_q.push_back(W'(i));
      wait_cyc(2);
      p0 = pop_cnt; x0 = xfer_cnt; first_pop_cyc = -1; first_xfer_cyc = -1;
      en = 1'b1; out_ready = 1'b1;
      wait_cyc(25);
      chk("stream_xfers", xfer_cnt - x0, 32'd16);
      chk("stream_latency", first_xfer_cyc - first_pop_cyc, 32'd1);
      chk("stream_back_to_back", last_xfer_cyc - first_xfer_cyc, 32'd15);
      en = 1'b0;
      wait_cyc(3);

      // Backpressure with 5 words queued
      out_ready = 1'b0;
      for (int i = 1; i <= 5; i++) fifo_q.push_back(W'(i));
      wait_cyc(2);
      p0 = pop_cnt; x0 = xfer_cnt;
      en = 1'b1;
      wait_cyc(6);
      chk("bp_pops", pop_cnt - p0, 32'd2);
      chk("bp_rinc", {31'd0, rinc}, 32'd0);
      chk("bp_out_data", {24'd0, out_data}, 32'h01);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      out_ready = 1'b1;
      wait_cyc(10);
      chk("bp_xfers", xfer_cnt - x0, 32'd5);
      chk("bp_none_left", exp_q.size(), 32'd0);
      en = 1'b0;
      wait_cyc(3);

      // Empty boundary
      p0 = pop_cnt; x0 = xfer_cnt;
      fifo_q.push_back(8'hA5);
      en = 1'b1;
      wait_cyc(5);
      chk("empty_one_pop", pop_cnt - p0, 32'd1);
      chk("empty_rinc_low", {31'd0, rinc}, 32'd0);
      fifo_q.push_back(8'h5A);
      wait_cyc(5);
      chk("empty_second_pop", pop_cnt - p0, 32'd2);
      chk("empty_xfers", xfer_cnt - x0, 32'd2);
      en = 1'b0;
      wait_cyc(3);

      // Drain from occ=2
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) fifo_q.push_back(W'(8'h30 + i));
      en = 1'b1;
      wait_cyc(6);
      chk("drain_full", {31'd0, out_valid}, 32'd1);
      p0 = pop_cnt; x0 = xfer_cnt;
      en = 1'b0; out_ready = 1'b1;
      wait_cyc(2);
      chk("drain_busy", {31'd0, busy}, 32'd0);
      chk("drain_state", {30'd0, state}, {30'd0, IDLE});
      chk("drain_xfers", xfer_cnt - x0, 32'd2);
      wait_cyc(3);
      chk("drain_no_pop", pop_cnt - p0, 32'd0);
      en = 1'b1;
      wait_cyc(10);
      en = 1'b0;
      wait_cyc(3);

      // Reset mid-burst with occ=2
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) fifo_q.push_back(W'(8'h60 + i));
      en = 1'b1;
      wait_cyc(5);
      chk("rst_mid_full", {31'd0, out_valid}, 32'd1);
      #2 rrst_n = 1'b0; en = 1'b0;
      #1;
      chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_rinc", {31'd0, rinc}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      wait_cyc(3);
      rrst_n = 1'b1;
      wait_cyc(2);
      x0 = xfer_cnt;
      fifo_q.push_back(8'h77); fifo_q.push_back(8'h78);
      en = 1'b1; out_ready = 1'b1;
      wait_cyc(6);
      chk("rst_post_xfers", xfer_cnt - x0, 32'd2);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 15) == 0) en = ~en;
         out_ready = ($urandom_range(0, 3) != 0);
         if (fifo_q.size() < 16 && $urandom_range(0, 2) != 0)
            fifo_q.push_back(W'($urandom));
         wait_cyc(1);
      end
      en = 1'b1; out_ready = 1'b1;
      begin
         int t = 0;
         while ((fifo_q.size() != 0 || exp_q.size() != 0) && t < 200) begin
            wait_cyc(1);
            t++;
         end
         chk("final_drain_timeout", {31'd0, t >= 200}, 32'd0);
      end

`ifdef FIFO_RD_WORD_CNT_EN
      rrst_n = 1'b0;
      wait_cyc(2);
      chk("cnt_reset", {16'd0, word_cnt}, 32'd0);
      rrst_n = 1'b1;
      en = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 70010; i++) begin
         while (fifo_q.size() < 4) fifo_q.push_back(W'($urandom));
         wait_cyc(1);
      end
      chk("cnt_model", {16'd0, word_cnt}, exp_cnt);
      chk("cnt_saturate", {16'd0, word_cnt}, 32'h0000FFFF);
      #2 rrst_n = 1'b0;
      #1;
      chk("cnt_async_clear", {16'd0, word_cnt}, 32'd0);
      wait_cyc(2);
      rrst_n = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
